// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit path.
//   - tx_state_t : frame controller states (IDLE, START, DATA, PARITY, STOP)
//   - START_BIT / STOP_BIT : line levels of the framing bits
//   - DATA_WIDTH : default payload width, also the serializer word width
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc
//   Combinational parity generator for the transmit frame.
//   Ports:
//     data    in  DATA_WIDTH  payload byte
//     par_typ in  1           0 = even, 1 = odd
//     par_bit out 1           bit that makes the frame parity match par_typ
//   Only instantiated when UART_TX_PARITY_EN is defined.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Frame controller for the UART transmitter. Sequences the shared bit
//   serializer to emit start bit, DATA_WIDTH data bits (LSB first), an
//   optional parity bit and a stop bit, and owns the TX line mux.
//
//   Ports:
//     CLK        in   bit clock, one bit time per cycle
//     nRESET     in   asynchronous active-low reset
//     P_DATA     in   byte to send, sampled on accept
//     Data_Valid in   send request, accepted in IDLE or STOP
//     PAR_EN     in   parity enable, sampled on accept
//     PAR_TYP    in   0 = even, 1 = odd, sampled on accept
//     ser_data   in   current serializer bit
//     ser_done   in   serializer last-bit flag
//     ser_en     out  serializer advance enable
//     TX_OUT     out  serial line, idle high
//     busy       out  frame in flight
//     sync_err   out  sticky: serializer last-bit flag disagreed with bit count
//
//   Build option: UART_TX_PARITY_EN compiles in the PARITY state and parity
//   logic. Without it PAR_EN/PAR_TYP are ignored and every frame is 10 bits.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   IDLE   | line idle high, waiting for Data_Valid
//   START  | start bit on the line, serializer primed
//   DATA   | serializer bits on the line, bit_cnt counts 0..DATA_WIDTH-1
//   PARITY | latched parity bit on the line
//   STOP   | stop bit; a new request here chains straight into START
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  sync_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sync_err_q, sync_err_d;

    logic accept;
    logic last_bit;
    logic par_frame;
    logic par_bit;

    assign accept   = Data_Valid && ((state_q == IDLE) || (state_q == STOP));
    assign last_bit = (bit_cnt_q == LAST_BIT);

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic par_bit_q, par_bit_d;
    logic par_bit_calc;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_bit_calc)
    );

    // Parity is resolved at accept time so P_DATA never reaches TX_OUT.
    always_comb begin
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bit_d = par_bit_q;
        if (accept) begin
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            par_bit_d = par_bit_calc;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign par_frame = par_en_q;
    assign par_bit   = par_bit_q;

    // The frame's parity type is held for debug visibility only; the
    // parity bit itself is already folded in at accept.
    logic unused_par_typ;
    assign unused_par_typ = par_typ_q;
`else
    assign par_frame = 1'b0;
    assign par_bit   = 1'b0;

    logic unused_par_inputs;
    assign unused_par_inputs = ^{P_DATA, PAR_EN, PAR_TYP};
`endif

    // State register
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_err_d = sync_err_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                // ser_done must coincide with our own last-bit count; any
                // disagreement is latched but the frame runs on our count.
                if (ser_done != last_bit) sync_err_d = 1'b1;
                if (last_bit) begin
                    bit_cnt_d = '0;
                    state_d   = par_frame ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = accept ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: TX_OUT depends only on state, latched parity and the
    // serializer's bit.
    always_comb begin
        TX_OUT = STOP_BIT;
        ser_en = 1'b0;
        busy   = 1'b0;
        case (state_q)
            IDLE: begin
                TX_OUT = STOP_BIT;
            end
            START: begin
                TX_OUT = START_BIT;
                ser_en = 1'b1;
                busy   = 1'b1;
            end
            DATA: begin
                TX_OUT = ser_data;
                ser_en = 1'b1;
                busy   = 1'b1;
            end
            PARITY: begin
                TX_OUT = par_bit;
                busy   = 1'b1;
            end
            STOP: begin
                TX_OUT = STOP_BIT;
                busy   = Data_Valid;
            end
            default: begin
                TX_OUT = STOP_BIT;
            end
        endcase
    end

    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    logic       CLK;
    logic       nRESET;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       TX_OUT;
    logic       busy;
    logic       sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_ctrl dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .sync_err   (sync_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as the line should carry it, index 0 first.
    function automatic logic [10:0] frame_word(input logic [7:0] d, input logic pe, input logic pt);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (PARITY_ON && pe) begin
            f[9]  = (^d) ^ pt;
            f[10] = 1'b1;
        end else begin
            f[9]  = 1'b1;
            f[10] = 1'b1;
        end
        return f;
    endfunction

    function automatic int frame_len(input logic pe);
        return (PARITY_ON && pe) ? 11 : 10;
    endfunction

    function automatic logic [11:0] line12(input logic [7:0] d, input logic pe, input logic pt);
        logic [10:0] f;
        logic [11:0] l;
        f = frame_word(d, pe, pt);
        l = '0;
        for (int i = 0; i < 12; i++) l = {l[10:0], (i < frame_len(pe)) ? f[i] : 1'b1};
        return l;
    endfunction

    // Serializer model: advances while ser_en, bit 0 visible after one
    // enabled cycle, ser_done on position done_pos (8 = correct last bit).
    logic [3:0] ser_pos;
    logic [7:0] ser_word = 8'h00;
    logic [3:0] done_pos = 4'd8;

    assign ser_data = (ser_pos >= 4'd1 && ser_pos <= 4'd8) ? ser_word[3'(ser_pos - 4'd1)] : 1'b0;
    assign ser_done = (ser_pos == done_pos);

    initial begin
        forever begin
            @(posedge CLK or negedge nRESET);
            if (!nRESET) ser_pos <= 4'd0;
            else         ser_pos <= ser_en ? ser_pos + 4'd1 : 4'd0;
        end
    end

    // Reference model: queue of line levels still owed for the current frame.
    logic exp_q[$];
    int   cur_len  = 10;
    logic exp_sync = 1'b0;
    bit   chk_en   = 1'b0;

    initial begin : ref_model
        int          off;
        bit          acc;
        logic [10:0] f;
        forever begin
            @(posedge CLK or negedge nRESET);
            if (!nRESET) begin
                exp_q.delete();
                exp_sync = 1'b0;
            end else begin
                if (exp_q.size() > 0) begin
                    off = cur_len - exp_q.size();
                    if (off >= 1 && off <= 8 && (ser_done != (off == 8))) exp_sync = 1'b1;
                end
                acc = Data_Valid && (exp_q.size() <= 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (acc) begin
                    f       = frame_word(P_DATA, PAR_EN, PAR_TYP);
                    cur_len = frame_len(PAR_EN);
                    for (int i = 0; i < cur_len; i++) exp_q.push_back(f[i]);
                    ser_word = P_DATA;
                end
            end
        end
    end

    initial begin : checker_proc
        forever begin
            @(negedge CLK);
            if (chk_en && nRESET) begin
                check_bit("tx_out", TX_OUT, (exp_q.size() > 0) ? exp_q[0] : 1'b1);
                check_bit("busy", busy, (exp_q.size() >= 2) || (exp_q.size() == 1 && Data_Valid));
                check_bit("ser_en", ser_en, (exp_q.size() > 0) && ((cur_len - exp_q.size()) <= 8));
                check_bit("sync_err", sync_err, exp_sync);
            end
        end
    end

    task automatic send_capture(input logic [7:0] d, input logic pe, input logic pt,
                                output logic [11:0] line, output int nbusy);
        @(negedge CLK); #1;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
        line  = '0;
        nbusy = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            line = {line[10:0], TX_OUT};
            if (busy) nbusy++;
            if (c == 0) begin
                #1;
                Data_Valid = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [11:0] line_p;
        logic [11:0] line_np;
        int          busy_p;
        int          busy_np;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        logic [11:0] line;
        int          nb;
        int          bad;
        int          len;
        logic [10:0] f1, f2;
        logic        expb;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 12'b010100101011, 12'b010100101111, 10, 9};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 12'b010000000011, 12'b010000000111, 10, 9};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 12'b010000000111, 12'b010000000111, 10, 9};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 12'b011111111111, 12'b011111111111,  9, 9};
        vecs[4] = '{8'h3C, 1'b1, 1'b0, 12'b000111100011, 12'b000111100111, 10, 9};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 12'b000000001011, 12'b000000001111, 10, 9};

        nRESET = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #12;
        check_bit("rst_tx_out", TX_OUT, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_ser_en", ser_en, 1'b0);
        check_bit("rst_sync_err", sync_err, 1'b0);
        @(negedge CLK); #1;
        nRESET = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge CLK);

        // Directed single frames
        for (int v = 0; v < 6; v++) begin
            send_capture(vecs[v].data, vecs[v].pe, vecs[v].pt, line, nb);
            check_val($sformatf("vec%0d_line", v), int'(line), int'(PARITY_ON ? vecs[v].line_p : vecs[v].line_np));
            check_val($sformatf("vec%0d_busy", v), nb, PARITY_ON ? vecs[v].busy_p : vecs[v].busy_np);
            check_bit($sformatf("vec%0d_sync", v), sync_err, 1'b0);
        end

        // Back-to-back: Data_Valid held through the first frame
        len = frame_len(1'b1);
        f1  = frame_word(8'h55, 1'b1, 1'b0);
        f2  = frame_word(8'h0F, 1'b1, 1'b0);
        @(negedge CLK); #1;
        P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        bad = 0; nb = 0;
        for (int c = 0; c <= 2 * len; c++) begin
            @(negedge CLK);
            expb = (c < len) ? f1[c] : (c < 2 * len) ? f2[c - len] : 1'b1;
            if (TX_OUT !== expb) bad++;
            if (busy) nb++;
            if (c == 0) begin #1; P_DATA = 8'h0F; end
            if (c == len) begin #1; Data_Valid = 1'b0; end
        end
        check_val("b2b_line_errs", bad, 0);
        check_val("b2b_busy", nb, 2 * len - 1);

        // Serializer raises ser_done on the 5th data cycle
        done_pos = 4'd5;
        send_capture(8'hC3, 1'b1, 1'b1, line, nb);
        check_val("fault_line", int'(line), int'(line12(8'hC3, 1'b1, 1'b1)));
        check_bit("fault_sync", sync_err, 1'b1);
        done_pos = 4'd8;
        send_capture(8'h5A, 1'b0, 1'b0, line, nb);
        check_val("after_fault_line", int'(line), int'(line12(8'h5A, 1'b0, 1'b0)));
        check_bit("sync_sticky", sync_err, 1'b1);

        // Reset during the 4th data bit
        @(negedge CLK); #1;
        P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK); #1;
        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        check_bit("pre_rst_bit3", TX_OUT, 1'b0);
        #3;
        nRESET = 1'b0;
        #1;
        check_bit("midrst_tx_out", TX_OUT, 1'b1);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_ser_en", ser_en, 1'b0);
        check_bit("midrst_sync", sync_err, 1'b0);
        @(negedge CLK); #1;
        nRESET = 1'b1;
        repeat (2) @(negedge CLK);
        check_bit("post_rst_idle", TX_OUT, 1'b1);
        send_capture(8'h3C, 1'b1, 1'b0, line, nb);
        check_val("post_rst_line", int'(line), int'(PARITY_ON ? vecs[4].line_p : vecs[4].line_np));
        check_bit("post_rst_sync", sync_err, 1'b0);

        // Random traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK); #1;
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
        end
        @(negedge CLK); #1;
        Data_Valid = 1'b0;
        repeat (14) @(negedge CLK);
        check_bit("final_idle", TX_OUT, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
